wb_rect_fill: RTL and testbench

- Wishbone master drawing engine that sits directly upstream of the VGA framebuffer slave.
- Accepts one rectangle-fill command at a time over a valid/ready handshake.
- Emits one Wishbone write per pixel, in raster order, into the framebuffer's pixel-indexed address space.
- Signals completion or error to the command source, typically a CPU-side register block or test pattern generator.

---
 rtl/wb_rect_fill_if.sv | 41 ++++
 rtl/wb_rect_fill.sv | 157 +++++++++++++++
 tb/tb_wb_rect_fill.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_rect_fill_if.sv
// Purpose : bundles the command handshake, status pulses and Wishbone master
//           bus of the rectangle-fill engine into one port.
// Latency : none (pure wiring).
// Backpr. : cmd_ready gates commands; ack_i stalls each Wishbone write.
// Ports (engine = master modport, environment = slave modport):
//   cmd_valid/cmd_ready, cmd_x/y/w/h/color : rectangle command handshake
//   abort                                  : cancel the fill in progress
//   busy, done, err                        : status, done/err are 1-cycle pulses
//   cyc_o, stb_o, we_o, addr_o, data_o     : Wishbone write cycle
//   ack_i                                  : Wishbone acknowledge
interface wb_rect_fill_if #(
   parameter int CW = 24
);
   logic          cmd_valid;
   logic          cmd_ready;
   logic [9:0]    cmd_x;
   logic [8:0]    cmd_y;
   logic [10:0]   cmd_w;
   logic [9:0]    cmd_h;
   logic [CW-1:0] cmd_color;
   logic          abort;
   logic          busy;
   logic          done;
   logic          err;
   logic          cyc_o;
   logic          stb_o;
   logic          we_o;
   logic [31:0]   addr_o;
   logic [31:0]   data_o;
   logic          ack_i;

   modport master (
      input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, abort, ack_i,
      output cmd_ready, busy, done, err, cyc_o, stb_o, we_o, addr_o, data_o
   );

   modport slave (
      output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, abort, ack_i,
      input  cmd_ready, busy, done, err, cyc_o, stb_o, we_o, addr_o, data_o
   );
endinterface

// File: rtl/wb_rect_fill.sv
// Purpose : Wishbone master that fills a rectangle of the framebuffer with one
//           colour, one write per pixel in raster order.
// Latency : handshake to first stb_o 2 cycles; final ack to done 2 cycles.
// Backpr. : one command at a time (cmd_ready low while busy); each write holds
//           until ack_i, back-to-back acks give one pixel per cycle.
// Ports   : clk, rst (async, active-high) plus the wb_rect_fill_if master
//           modport (command handshake, abort, busy/done/err, Wishbone bus).
// Option  : RECT_CLIP_EN defined -> clip rectangles to the screen instead of
//           rejecting any rectangle that crosses the screen edge.
module wb_rect_fill #(
   parameter int          VGA_WIDTH       = 640,
   parameter int          VGA_HEIGHT      = 480,
   parameter int          VGA_COLOR_DEPTH = 8,
   parameter logic [31:0] BASE_ADDR       = 32'h0
)(
   input  logic           clk,
   input  logic           rst,
   wb_rect_fill_if.master bus
);
   localparam int          CW  = 3 * VGA_COLOR_DEPTH;
   localparam logic [31:0] W32 = 32'(VGA_WIDTH);
   localparam logic [31:0] H32 = 32'(VGA_HEIGHT);

   // S_DROP is the single bus-idle cycle between the last (or aborted) write
   // and the done pulse.
   typedef enum logic [2:0] {S_IDLE, S_CHECK, S_WRITE, S_DROP, S_FIN} state_t;

   state_t        r_state, w_state_nxt;
   logic [31:0]   r_x, r_y, r_w, r_h;
   logic [31:0]   r_cur_x, r_cur_y, r_row_base;
   logic [CW-1:0] r_color;
   logic          r_err;

   logic [31:0]   w_nx, w_eff_w, w_eff_h;
   logic          w_row_wrap, w_last, w_zero, w_range_err;
   logic          w_cmd_ready, w_busy, w_done, w_bus_en;

   // y * VGA_WIDTH as a sum of shifted copies of y; only used once per command.
   function automatic logic [31:0] mul_width(input logic [31:0] y);
      logic [31:0] acc;
      acc = '0;
      for (int i = 0; i < 32; i++)
         if (W32[i]) acc = acc + (y << i);
      return acc;
   endfunction

   assign w_nx       = r_cur_x + 32'd1;
   assign w_row_wrap = (w_nx == r_x + r_w);
   assign w_last     = w_row_wrap && (r_cur_y + 32'd1 == r_y + r_h);
   assign w_zero     = (r_w == 32'd0) || (r_h == 32'd0);

`ifdef RECT_CLIP_EN
   // Origin off screen is an error; otherwise trim to the visible part.
   assign w_range_err = (r_x >= W32) || (r_y >= H32);
   assign w_eff_w     = (r_w > W32 - r_x) ? (W32 - r_x) : r_w;
   assign w_eff_h     = (r_h > H32 - r_y) ? (H32 - r_y) : r_h;
`else
   assign w_range_err = (r_x + r_w > W32) || (r_y + r_h > H32);
   assign w_eff_w     = r_w;
   assign w_eff_h     = r_h;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cmd_ready = 1'b0;
      w_busy      = 1'b1;
      w_done      = 1'b0;
      w_bus_en    = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_cmd_ready = 1'b1;
            w_busy      = 1'b0;
            if (bus.cmd_valid) w_state_nxt = S_CHECK;
         end
         S_CHECK: begin
            if (w_zero || w_range_err) w_state_nxt = S_FIN;
            else                       w_state_nxt = S_WRITE;
         end
         S_WRITE: begin
            w_bus_en = 1'b1;
            if (bus.abort || (bus.ack_i && w_last)) w_state_nxt = S_DROP;
         end
         S_DROP: w_state_nxt = S_FIN;
         S_FIN: begin
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_x        <= '0;
         r_y        <= '0;
         r_w        <= '0;
         r_h        <= '0;
         r_cur_x    <= '0;
         r_cur_y    <= '0;
         r_row_base <= '0;
         r_color    <= '0;
         r_err      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.cmd_valid) begin
                  r_x     <= 32'(bus.cmd_x);
                  r_y     <= 32'(bus.cmd_y);
                  r_w     <= 32'(bus.cmd_w);
                  r_h     <= 32'(bus.cmd_h);
                  r_color <= bus.cmd_color;
                  r_err   <= 1'b0;
               end
            end
            S_CHECK: begin
               // Empty rectangles take precedence over range errors.
               r_err      <= !w_zero && w_range_err;
               r_w        <= w_eff_w;
               r_h        <= w_eff_h;
               r_cur_x    <= r_x;
               r_cur_y    <= r_y;
               r_row_base <= mul_width(r_y);
            end
            S_WRITE: begin
               if (bus.abort) r_err <= 1'b1;
               if (bus.ack_i) begin
                  if (w_row_wrap) begin
                     r_cur_x    <= r_x;
                     r_cur_y    <= r_cur_y + 32'd1;
                     r_row_base <= r_row_base + W32;
                  end else begin
                     r_cur_x <= w_nx;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Bus outputs decode straight from the state register so a reset drops
   // cyc_o/stb_o without waiting for a clock edge.
   assign bus.cmd_ready = w_cmd_ready;
   assign bus.busy      = w_busy;
   assign bus.done      = w_done;
   assign bus.err       = w_done && r_err;
   assign bus.cyc_o     = w_bus_en;
   assign bus.stb_o     = w_bus_en;
   assign bus.we_o      = w_bus_en;
   assign bus.addr_o    = w_bus_en ? (BASE_ADDR + r_row_base + r_cur_x) : 32'd0;
   assign bus.data_o    = w_bus_en ? 32'(r_color) : 32'd0;
endmodule

// File: tb/tb_wb_rect_fill.sv
module tb_wb_rect_fill;
   localparam int          W    = 640;
   localparam int          H    = 480;
   localparam logic [31:0] BASE = 32'h0;

   typedef struct packed { logic [31:0] a; logic [31:0] d; } wr_t;
   typedef struct { int nwr; bit err; } done_t;

   logic clk;
   logic rst;
   wb_rect_fill_if #(.CW(24)) bus();

   wb_rect_fill #(
      .VGA_WIDTH(W), .VGA_HEIGHT(H), .VGA_COLOR_DEPTH(8), .BASE_ADDR(BASE)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   wr_t   exp_wr[$];
   done_t exp_done[$];
   int    tests    = 0;
   int    fails    = 0;
   int    cyc_n    = 0;
   int    gap      = 0;
   int    grants   = 0;
   int    abort_at = -1;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc_n++;
   end

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc_n);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b expected %b at cycle %0d", name, act, exp, cyc_n);
      end
   endtask

   // Reference model: list of pixel writes the command must produce, in
   // raster order, plus the completion status. limit truncates the list.
   task automatic model(input int x, input int y, input int w, input int h,
                        input logic [23:0] col, input int limit, input bit force_err);
      int ew, eh, n;
      bit e;
      wr_t t;
      n = 0; e = 1'b0; ew = w; eh = h;
      if (w == 0 || h == 0) begin
         ew = 0; eh = 0;
      end
`ifdef RECT_CLIP_EN
      else if (x >= W || y >= H) begin
         e = 1'b1; ew = 0; eh = 0;
      end else begin
         if (x + w > W) ew = W - x;
         if (y + h > H) eh = H - y;
      end
`else
      else if (x + w > W || y + h > H) begin
         e = 1'b1; ew = 0; eh = 0;
      end
`endif
      for (int r = 0; r < eh; r++)
         for (int c = 0; c < ew; c++)
            if (limit < 0 || n < limit) begin
               t.a = BASE + 32'((y + r) * W + x + c);
               t.d = {8'h00, col};
               exp_wr.push_back(t);
               n++;
            end
      exp_done.push_back('{n, e | force_err});
   endtask

   // Push expectations, then present the command until it is accepted.
   task automatic do_cmd(input int x, input int y, input int w, input int h,
                         input logic [23:0] col, input int limit, input bit force_err);
      bit ok;
      model(x, y, w, h, col, limit, force_err);
      @(posedge clk); #1;
      bus.cmd_x     = 10'(x);
      bus.cmd_y     = 9'(y);
      bus.cmd_w     = 11'(w);
      bus.cmd_h     = 10'(h);
      bus.cmd_color = col;
      bus.cmd_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (bus.cmd_ready) begin ok = 1'b1; break; end
      end
      if (!ok) chk1("cmd_accept_timeout", 1'b0, 1'b1);
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 20000; i++) begin
         @(negedge clk);
         if (exp_done.size() == 0 && bus.cmd_ready) begin ok = 1'b1; break; end
      end
      if (!ok) chk1("idle_timeout", 1'b0, 1'b1);
   endtask

   // Wishbone slave: acks after `gap` wait cycles; raises abort together
   // with grant number abort_at.
   initial begin
      int cnt;
      cnt = 0;
      bus.ack_i = 1'b0;
      bus.abort = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (rst || !(bus.cyc_o && bus.stb_o)) begin
            bus.ack_i = 1'b0; bus.abort = 1'b0; cnt = 0;
         end else if (cnt >= gap) begin
            grants++;
            bus.ack_i = 1'b1;
            bus.abort = (grants == abort_at);
            cnt = 0;
         end else begin
            bus.ack_i = 1'b0; bus.abort = 1'b0; cnt++;
         end
      end
   end

   // Monitor / scoreboard.
   initial begin
      bit  hs_ok, wr_active, hold, abort_pend;
      int  hs_cyc, last_ack, n_wr;
      logic [31:0] prev_addr, prev_data;
      wr_t   w;
      done_t d;
      hs_ok = 0; wr_active = 0; hold = 0; abort_pend = 0;
      hs_cyc = 0; last_ack = 0; n_wr = 0; prev_addr = '0; prev_data = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            hs_ok = 0; wr_active = 0; hold = 0; abort_pend = 0; n_wr = 0;
         end else begin
            chk1("ready_vs_busy", bus.cmd_ready, !bus.busy);
            if (abort_pend) begin
               chk1("abort_cyc_drop", bus.cyc_o, 1'b0);
               abort_pend = 0;
            end
            if (bus.cyc_o && bus.stb_o) begin
               if (!bus.we_o) chk1("we_o", bus.we_o, 1'b1);
               if (!wr_active) begin
                  wr_active = 1;
                  if (hs_ok) chk32("hs_to_stb", cyc_n - hs_cyc, 32'd2);
               end else if (hold) begin
                  chk32("stable_addr", bus.addr_o, prev_addr);
                  chk32("stable_data", bus.data_o, prev_data);
               end
               if (bus.ack_i) begin
                  if (exp_wr.size() == 0) begin
                     chk32("unexpected_write", bus.addr_o, 32'hFFFF_FFFF);
                  end else begin
                     w = exp_wr.pop_front();
                     chk32("wr_addr", bus.addr_o, w.a);
                     chk32("wr_data", bus.data_o, w.d);
                  end
                  n_wr++;
                  last_ack   = cyc_n;
                  hold       = 0;
                  abort_pend = bus.abort;
               end else begin
                  hold = 1; prev_addr = bus.addr_o; prev_data = bus.data_o;
               end
            end else begin
               hold = 0;
               chk1("stb_without_cyc", bus.stb_o, 1'b0);
            end
            if (bus.done) begin
               if (exp_done.size() == 0) begin
                  chk1("unexpected_done", bus.done, 1'b0);
               end else begin
                  d = exp_done.pop_front();
                  chk1("done_err", bus.err, d.err);
                  chk32("write_count", n_wr, d.nwr);
                  if (hs_ok)
                     chk32("done_latency", cyc_n - ((n_wr > 0) ? last_ack : hs_cyc), 32'd2);
               end
               hs_ok = 0; wr_active = 0;
            end else begin
               chk1("err_without_done", bus.err, 1'b0);
            end
            if (bus.cmd_valid && bus.cmd_ready) begin
               hs_ok = 1; hs_cyc = cyc_n; n_wr = 0; wr_active = 0;
            end
         end
      end
   end

   // Stimulus.
   initial begin
      int x, y, w, h;
      rst = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_x = '0; bus.cmd_y = '0; bus.cmd_w = '0; bus.cmd_h = '0;
      bus.cmd_color = '0;
      #1;
      chk1("rst_cmd_ready", bus.cmd_ready, 1'b1);
      chk1("rst_busy", bus.busy, 1'b0);
      chk1("rst_done", bus.done, 1'b0);
      chk1("rst_err", bus.err, 1'b0);
      chk1("rst_cyc", bus.cyc_o, 1'b0);
      chk1("rst_stb", bus.stb_o, 1'b0);
      chk1("rst_we", bus.we_o, 1'b0);
      chk32("rst_addr", bus.addr_o, 32'd0);
      chk32("rst_data", bus.data_o, 32'd0);
      repeat (3) @(posedge clk);
      #3 rst = 1'b0;

      // Directed cases.
      gap = 0; do_cmd(2, 1, 3, 2, 24'hFF0000, -1, 1'b0);   wait_idle();
      gap = 2; do_cmd(639, 479, 1, 1, 24'h12AB34, -1, 1'b0); wait_idle();
      gap = 0; do_cmd(5, 5, 0, 3, 24'h00FF00, -1, 1'b0);   wait_idle();
      do_cmd(630, 0, 20, 1, 24'h0000FF, -1, 1'b0);        wait_idle();

      // Abort together with the 5th ack of a 4x4 fill.
      abort_at = grants + 5;
      do_cmd(100, 50, 4, 4, 24'hABCDEF, 5, 1'b1);
      wait_idle();
      abort_at = -1;
      @(negedge clk);
      chk1("abort_ready_after", bus.cmd_ready, 1'b1);

      // Reset in the 4th WRITE cycle of a 4x4 fill.
      do_cmd(10, 10, 4, 4, 24'h555555, -1, 1'b0);
      repeat (4) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk1("midrst_cyc", bus.cyc_o, 1'b0);
      chk1("midrst_stb", bus.stb_o, 1'b0);
      chk1("midrst_busy", bus.busy, 1'b0);
      exp_wr.delete();
      exp_done.delete();
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      @(negedge clk);
      chk1("post_rst_ready", bus.cmd_ready, 1'b1);
      do_cmd(3, 2, 2, 2, 24'h0F0F0F, -1, 1'b0);
      wait_idle();

      // Randomized commands issued back to back with random slave wait states.
      for (int n = 0; n < 40; n++) begin
         x = ($urandom_range(0, 3) == 0) ? W - 1 - $urandom_range(0, 6) : $urandom_range(0, W - 1);
         y = ($urandom_range(0, 3) == 0) ? H - 1 - $urandom_range(0, 3) : $urandom_range(0, H - 1);
         if ($urandom_range(0, 9) == 0) x = $urandom_range(W, 1023);
         if ($urandom_range(0, 9) == 0) y = $urandom_range(H, 511);
         w = $urandom_range(0, 8);
         h = $urandom_range(0, 4);
         gap = $urandom_range(0, 3);
         do_cmd(x, y, w, h, 24'($urandom), -1, 1'b0);
      end
      wait_idle();

      chk32("wr_queue_empty", exp_wr.size(), 32'd0);
      chk32("done_queue_empty", exp_done.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #900000;
      fails++;
      $display("FAIL watchdog: simulation did not finish, expected completion before %0d cycles", cyc_n);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1);
   end
endmodule
